// File: rtl/atm_keypad_front.sv
// Keypad front end for the ATM controller: collects account, PIN, operation,
// amount and new PIN from keystrokes, issues one held request and latches the reply.
module atm_keypad_front #(
    parameter logic [2:0]  OP_BALANCE     = 3'd3,
    parameter logic [2:0]  OP_WITHDRAW    = 3'd4,
    parameter logic [2:0]  OP_DEPOSIT     = 3'd5,
    parameter logic [2:0]  OP_CHANGE_PIN  = 3'd6,
    parameter int unsigned MAX_AMT_DIGITS = 9,
    parameter int unsigned TIMEOUT        = 1000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        key_valid_i,
    input  logic [3:0]  key_code_i,
    input  logic        language_i,
    input  logic        req_ready_i,
    input  logic        resp_valid_i,
    input  logic        resp_success_i,
    input  logic [31:0] resp_balance_i,
    output logic        req_valid_o,
    output logic [3:0]  acc_num_o,
    output logic [15:0] pin_o,
    output logic [15:0] new_pin_o,
    output logic [31:0] amount_o,
    output logic [2:0]  operation_o,
    output logic        language_o,
    output logic        done_o,
    output logic        result_success_o,
    output logic [31:0] result_balance_o,
    output logic        timeout_o,
    output logic [2:0]  fsm_state_o
);

    typedef enum logic [2:0] {
        StAcc    = 3'd0,
        StPin    = 3'd1,
        StOp     = 3'd2,
        StAmt    = 3'd3,
        StNewPin = 3'd4,
        StReq    = 3'd5,
        StWait   = 3'd6,
        StDone   = 3'd7
    } state_e;

    localparam logic [3:0]  KeyEnter  = 4'hA;
    localparam logic [3:0]  KeyCancel = 4'hB;
    localparam logic [3:0]  KeyClear  = 4'hC;
    localparam logic [3:0]  AmtMax    = 4'(MAX_AMT_DIGITS);
    localparam logic [31:0] WaitLast  = 32'(TIMEOUT - 1);

    state_e      state_q;
    logic        has_digit_q;
    logic [2:0]  pin_cnt_q;
    logic [2:0]  new_pin_cnt_q;
    logic [3:0]  amt_cnt_q;
    logic [31:0] wait_cnt_q;
    logic        req_valid_q;
    logic [3:0]  acc_num_q;
    logic [15:0] pin_q;
    logic [15:0] new_pin_q;
    logic [31:0] amount_q;
    logic [2:0]  operation_q;
    logic        language_q;
    logic        done_q;
    logic        result_success_q;
    logic [31:0] result_balance_q;
    logic        timeout_q;

    logic        is_digit;
    logic        is_enter;
    logic        is_cancel;
    logic        is_clear;
    logic [31:0] amt_next;

    // Keystroke decode and the decimal accumulate step for the amount field
    always_comb begin
        is_digit  = key_valid_i && (key_code_i <= 4'd9);
        is_enter  = key_valid_i && (key_code_i == KeyEnter);
        is_cancel = key_valid_i && (key_code_i == KeyCancel);
        is_clear  = key_valid_i && (key_code_i == KeyClear);
        amt_next  = (amount_q * 32'd10) + {28'd0, key_code_i};
    end

    // Entry FSM, request handshake and response capture, all outputs registered
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q          <= StAcc;
            has_digit_q      <= 1'b0;
            pin_cnt_q        <= '0;
            new_pin_cnt_q    <= '0;
            amt_cnt_q        <= '0;
            wait_cnt_q       <= '0;
            req_valid_q      <= 1'b0;
            acc_num_q        <= '0;
            pin_q            <= '0;
            new_pin_q        <= '0;
            amount_q         <= '0;
            operation_q      <= '0;
            language_q       <= 1'b0;
            done_q           <= 1'b0;
            result_success_q <= 1'b0;
            result_balance_q <= '0;
            timeout_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // Cancel during entry and the DONE cycle both drop the session
            if ((is_cancel && (state_q <= StNewPin)) || (state_q == StDone)) begin
                state_q       <= StAcc;
                has_digit_q   <= 1'b0;
                pin_cnt_q     <= '0;
                new_pin_cnt_q <= '0;
                amt_cnt_q     <= '0;
                acc_num_q     <= '0;
                pin_q         <= '0;
                new_pin_q     <= '0;
                amount_q      <= '0;
                operation_q   <= '0;
            end else begin
                case (state_q)
                    StAcc: begin
                        if (is_digit) begin
                            acc_num_q   <= key_code_i;
                            has_digit_q <= 1'b1;
                            if (!has_digit_q) language_q <= language_i;
                        end else if (is_clear) begin
                            acc_num_q   <= '0;
                            has_digit_q <= 1'b0;
                        end else if (is_enter && has_digit_q) begin
                            state_q <= StPin;
                        end
                    end
                    StPin: begin
                        if (is_digit && (pin_cnt_q != 3'd4)) begin
                            pin_q     <= {pin_q[11:0], key_code_i};
                            pin_cnt_q <= pin_cnt_q + 3'd1;
                        end else if (is_clear) begin
                            pin_q     <= '0;
                            pin_cnt_q <= '0;
                        end else if (is_enter && (pin_cnt_q == 3'd4)) begin
                            state_q <= StOp;
                        end
                    end
                    StOp: begin
                        if (is_digit) begin
                            case (key_code_i)
                                4'd1: begin
                                    operation_q <= OP_BALANCE;
                                    req_valid_q <= 1'b1;
                                    state_q     <= StReq;
                                end
                                4'd2: begin
                                    operation_q <= OP_WITHDRAW;
                                    state_q     <= StAmt;
                                end
                                4'd3: begin
                                    operation_q <= OP_DEPOSIT;
                                    state_q     <= StAmt;
                                end
                                4'd4: begin
                                    operation_q <= OP_CHANGE_PIN;
                                    state_q     <= StNewPin;
                                end
                                default: ;
                            endcase
                        end
                    end
                    StAmt: begin
                        if (is_digit && (amt_cnt_q < AmtMax)) begin
                            amount_q  <= amt_next;
                            amt_cnt_q <= amt_cnt_q + 4'd1;
                        end else if (is_clear) begin
                            amount_q  <= '0;
                            amt_cnt_q <= '0;
                        end else if (is_enter && (amt_cnt_q != 4'd0)) begin
                            req_valid_q <= 1'b1;
                            state_q     <= StReq;
                        end
                    end
                    StNewPin: begin
                        if (is_digit && (new_pin_cnt_q != 3'd4)) begin
                            new_pin_q     <= {new_pin_q[11:0], key_code_i};
                            new_pin_cnt_q <= new_pin_cnt_q + 3'd1;
                        end else if (is_clear) begin
                            new_pin_q     <= '0;
                            new_pin_cnt_q <= '0;
                        end else if (is_enter && (new_pin_cnt_q == 3'd4)) begin
                            req_valid_q <= 1'b1;
                            state_q     <= StReq;
                        end
                    end
                    StReq: begin
                        if (req_ready_i) begin
                            req_valid_q <= 1'b0;
                            wait_cnt_q  <= '0;
                            state_q     <= StWait;
                        end
                    end
                    StWait: begin
                        // A response on the final count still beats the timeout
                        if (resp_valid_i) begin
                            result_success_q <= resp_success_i;
                            result_balance_q <= resp_balance_i;
                            timeout_q        <= 1'b0;
                            done_q           <= 1'b1;
                            state_q          <= StDone;
                        end else if (wait_cnt_q == WaitLast) begin
                            result_success_q <= 1'b0;
                            timeout_q        <= 1'b1;
                            done_q           <= 1'b1;
                            state_q          <= StDone;
                        end else begin
                            wait_cnt_q <= wait_cnt_q + 32'd1;
                        end
                    end
                    default: state_q <= StAcc;
                endcase
            end
        end
    end

    assign req_valid_o      = req_valid_q;
    assign acc_num_o        = acc_num_q;
    assign pin_o            = pin_q;
    assign new_pin_o        = new_pin_q;
    assign amount_o         = amount_q;
    assign operation_o      = operation_q;
    assign language_o       = language_q;
    assign done_o           = done_q;
    assign result_success_o = result_success_q;
    assign result_balance_o = result_balance_q;
    assign timeout_o        = timeout_q;
    assign fsm_state_o      = state_q;

endmodule

// File: doc/atm_keypad_front.md
# atm_keypad_front

Customer-side front end for the ATM controller. Consumes keypad keystrokes and assembles account number, PIN, operation, amount and new PIN. Presents them to the ATM controller as a single held request, then waits for the controller's response and latches the result. It is the initiator end of the ATM transaction interface; the ATM controller is the responder.

## Interface
Parameters:
- OP_BALANCE, 3, operation code driven for menu key 1
- OP_WITHDRAW, 4, operation code for menu key 2
- OP_DEPOSIT, 5, operation code for menu key 3
- OP_CHANGE_PIN, 6, operation code for menu key 4
- MAX_AMT_DIGITS, 9, maximum decimal digits accepted for amount
- TIMEOUT, 1000, cycles to wait for a response before aborting

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous active-high reset
- key_valid  in  1  keystroke present this cycle
- key_code  in  4  0-9 digit, 0xA ENTER, 0xB CANCEL, 0xC CLEAR, others ignored
- language_in  in  1  language select, latched with the first account digit
- req_ready  in  1  ATM accepts request
- resp_valid  in  1  ATM result valid (1-cycle pulse)
- resp_success  in  1  ATM success flag
- resp_balance  in  32  ATM balance
- req_valid  out  1  request pending
- acc_num  out  4  account digit
- pin  out  16  PIN, 4 BCD nibbles, first-entered digit in [15:12]
- new_pin  out  16  new PIN, same packing
- amount  out  32  binary amount
- operation  out  3  operation code
- language  out  1  latched language
- done  out  1  1-cycle pulse: transaction finished
- result_success  out  1  latched success
- result_balance  out  32  latched balance
- timeout  out  1  latched: last transaction timed out
- fsm_state  out  3  current state encoding

## Operation
- Encoding of states: ACC=0, PIN=1, OP=2, AMT=3, NEWPIN=4, REQ=5, WAIT=6, DONE=7.
- Reset:
  - State goes to ACC.
  - Every output and every internal field and counter goes to 0.
- ACC:
  - A digit sets acc_num to that digit (last digit wins) and sets the has-digit flag. The first digit of a session also latches language_in.
  - ENTER with has-digit moves to PIN. ENTER without has-digit is ignored.
- PIN:
  - A digit shifts in: pin <= {pin[11:0], d}, with the count incremented. While the count is 4, further digits are ignored.
  - ENTER with count 4 moves to OP. ENTER with count below 4 is ignored.
- OP:
  - Digit 1 sets operation=OP_BALANCE and moves to REQ.
  - Digit 2 sets OP_WITHDRAW and moves to AMT.
  - Digit 3 sets OP_DEPOSIT and moves to AMT.
  - Digit 4 sets OP_CHANGE_PIN and moves to NEWPIN.
  - All other keys are ignored.
- AMT:
  - A digit updates amount <= amount*10 + d while the count is below MAX_AMT_DIGITS; further digits are ignored. With 9 digits the maximum is 999999999, so no 32-bit overflow is possible.
  - ENTER with count ≥1 moves to REQ.
- NEWPIN: same rules as PIN on new_pin; ENTER with count 4 moves to REQ.
- CLEAR in PIN/AMT/NEWPIN zeroes that field and its count. In ACC it zeroes acc_num and has-digit. In OP it is ignored.
- CANCEL in ACC through NEWPIN:
  - Returns to ACC.
  - Zeroes acc_num, pin, new_pin, amount, operation and all counts.
  - No request is issued and done is not pulsed.
- REQ:
  - req_valid=1. All request fields are held stable.
  - On the edge where req_ready=1, req_valid drops and the state moves to WAIT.
- WAIT:
  - The cycle counter starts at 0 on entry.
  - On resp_valid=1: latch result_success and result_balance, clear timeout, move to DONE.
  - If the counter reaches TIMEOUT-1 with no response: result_success=0, result_balance is unchanged, timeout=1, move to DONE.
  - If resp_valid and the timeout coincide, the response wins.
- DONE:
  - done=1 for exactly this cycle.
  - Next state is ACC, with request fields and counts cleared.
  - result_success, result_balance and timeout hold until the next DONE or reset.
- Keys arriving in REQ, WAIT or DONE are dropped. resp_valid is ignored outside WAIT.

## Timing
- Keys are sampled on the posedge with key_valid=1, one key per cycle. The field and state update is visible the next cycle.
- req_valid asserts the cycle after the final ENTER, or after menu key 1.
- Handshake: the transfer occurs on the edge with req_valid&&req_ready. req_ready may be tied high, which gives a 1-cycle REQ.
- The earliest accepted resp_valid is the cycle after the state becomes WAIT. done asserts the cycle after resp_valid is sampled.
- A timeout produces done exactly TIMEOUT cycles after WAIT entry.
- Reset asserted mid-transaction (including REQ or WAIT) aborts on that edge: req_valid=0 the next cycle, and done is not pulsed.

## Test plan
- Balance path:
  - Stimulus: keys 3,ENTER,1,2,3,4,ENTER,1; req_ready=1; resp_valid one cycle later with success=1, balance=500.
  - Required: pin=0x1234, acc_num=3, operation=3 on request; done pulse; result_balance=500.
- Withdraw amount:
  - Stimulus: keys 1,ENTER,0,0,0,0,ENTER,2,2,5,0,ENTER.
  - Required: amount=250, operation=4 while req_valid. With req_ready held low 5 cycles, fields stay stable and req_valid stays 1.
- Limits and length gating:
  - PIN with 5 digits 9,8,7,6,5: pin=0x9876.
  - PIN ENTER after 3 digits: state stays PIN.
  - Amount with 10 nines: amount=999999999.
- Cancel and clear:
  - CLEAR in AMT after 7,7 then 4,ENTER: amount=4.
  - CANCEL in NEWPIN: state ACC, all fields 0, no req_valid, no done.
- Timeout: with TIMEOUT=8 and no resp_valid, done occurs 8 cycles after WAIT entry with timeout=1 and result_success=0. A later good transaction clears timeout.
- Reset in WAIT: assert rst for one cycle. Required: state 0, outputs 0, no done; a late resp_valid is ignored.
